// File: rtl/id_issue_ctrl.sv
// Decode/issue front end: instruction FIFO, head decode, GPR and HI/LO scoreboard.
// Optional macro WB_BYPASS_EN lets a same-cycle writeback clear a pending hazard.
module id_issue_ctrl #(
    parameter int unsigned IBUF_DEPTH = 4,
    parameter int unsigned PC_W       = 30,
    parameter int unsigned NREG       = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          if_valid,
    output logic                          if_ready,
    input  logic [31:0]                   if_inst,
    input  logic [PC_W-1:0]               if_pc,
    output logic                          id_valid,
    input  logic                          id_ready,
    output logic [31:0]                   id_inst,
    output logic [PC_W-1:0]               id_pc,
    output logic [4:0]                    id_rs,
    output logic [4:0]                    id_rt,
    output logic [4:0]                    id_rd,
    output logic                          id_hilo_wr,
    output logic                          id_illegal,
    input  logic                          wb_en,
    input  logic [4:0]                    wb_addr,
    input  logic                          hilo_wb_en,
    output logic [3:0]                    lockreq,
    output logic [$clog2(IBUF_DEPTH):0]   occupancy
);
    localparam int unsigned AW = $clog2(IBUF_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [31:0]     mem_inst [IBUF_DEPTH];
    logic [PC_W-1:0] mem_pc   [IBUF_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [NREG-1:0] busy_q, busy_d, busy_eff, wb_clr, set_vec;
    logic            hilo_busy_q, hilo_busy_d, hilo_eff;
    logic            empty, push, pop;
    logic            rs_used, rt_used, hilo_rd, hilo_wr, legal;
    logic [4:0]      dest;
    logic [5:0]      op, fn;
    logic [4:0]      f_rs, f_rt, f_rd;

    assign empty     = (count_q == '0);
    assign if_ready  = (count_q != CW'(IBUF_DEPTH));
    assign push      = if_valid & if_ready;
    assign pop       = id_valid & id_ready;
    assign occupancy = count_q;

    assign id_inst = empty ? 32'h0 : mem_inst[rd_ptr_q];
    assign id_pc   = empty ? '0 : mem_pc[rd_ptr_q];
    assign op      = id_inst[31:26];
    assign fn      = id_inst[5:0];
    assign f_rs    = id_inst[25:21];
    assign f_rt    = id_inst[20:16];
    assign f_rd    = id_inst[15:11];

    always_comb begin
        rs_used = 1'b0;
        rt_used = 1'b0;
        hilo_rd = 1'b0;
        hilo_wr = 1'b0;
        legal   = 1'b0;
        dest    = 5'd0;
        case (op)
            6'h00: begin
                case (fn)
                    6'h00, 6'h02, 6'h03: begin legal = 1'b1; rt_used = 1'b1; dest = f_rd; end
                    6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B: begin
                        legal = 1'b1; rs_used = 1'b1; rt_used = 1'b1; dest = f_rd;
                    end
                    6'h08: begin legal = 1'b1; rs_used = 1'b1; end
                    6'h09: begin legal = 1'b1; rs_used = 1'b1; dest = f_rd; end
                    6'h0C, 6'h0D: legal = 1'b1;
                    6'h10, 6'h12: begin legal = 1'b1; hilo_rd = 1'b1; dest = f_rd; end
                    6'h11, 6'h13: begin legal = 1'b1; rs_used = 1'b1; hilo_wr = 1'b1; end
                    6'h18, 6'h19, 6'h1A, 6'h1B: begin
                        legal = 1'b1; rs_used = 1'b1; rt_used = 1'b1; hilo_wr = 1'b1;
                    end
                    default: ;
                endcase
            end
            // REGIMM: rt field selects the branch flavour
            6'h01: begin
                case (f_rt)
                    5'h00, 5'h01: begin legal = 1'b1; rs_used = 1'b1; end
                    5'h10, 5'h11: begin legal = 1'b1; rs_used = 1'b1; dest = 5'd31; end
                    default: ;
                endcase
            end
            6'h02: legal = 1'b1;
            6'h03: begin legal = 1'b1; dest = 5'd31; end
            6'h04, 6'h05: begin legal = 1'b1; rs_used = 1'b1; rt_used = 1'b1; end
            6'h06, 6'h07: begin legal = 1'b1; rs_used = 1'b1; end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin legal = 1'b1; rs_used = 1'b1; dest = f_rt; end
            6'h0F: begin legal = 1'b1; dest = f_rt; end
            6'h10: begin
                if (f_rs == 5'h00) begin legal = 1'b1; dest = f_rt; end
                else if (f_rs == 5'h04) begin legal = 1'b1; rt_used = 1'b1; end
            end
            6'h28, 6'h29, 6'h2B: begin legal = 1'b1; rs_used = 1'b1; rt_used = 1'b1; end
            default: ;
        endcase
    end

    assign id_rs      = rs_used ? f_rs : 5'd0;
    assign id_rt      = rt_used ? f_rt : 5'd0;
    assign id_rd      = dest;
    assign id_hilo_wr = hilo_wr;
    assign id_illegal = ~empty & ~legal;

    assign wb_clr = wb_en ? (NREG'(1) << wb_addr) : '0;
`ifdef WB_BYPASS_EN
    assign busy_eff = busy_q & ~wb_clr;
    assign hilo_eff = hilo_busy_q & ~hilo_wb_en;
`else
    assign busy_eff = busy_q;
    assign hilo_eff = hilo_busy_q;
`endif

    // Unused sources already read as index 0, which is never busy.
    assign lockreq[0] = ~empty & (id_rs != 5'd0) & busy_eff[id_rs];
    assign lockreq[1] = ~empty & (id_rt != 5'd0) & busy_eff[id_rt];
    assign lockreq[2] = ~empty & (id_rd != 5'd0) & busy_eff[id_rd];
    assign lockreq[3] = ~empty & (hilo_rd | hilo_wr) & hilo_eff;
    assign id_valid   = ~empty & ~|lockreq;

    assign set_vec = (pop && id_rd != 5'd0) ? (NREG'(1) << id_rd) : '0;

    always_comb begin
        busy_d      = (busy_q & ~wb_clr) | set_vec;
        busy_d[0]   = 1'b0;
        hilo_busy_d = (hilo_busy_q & ~hilo_wb_en) | (pop & id_hilo_wr);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            busy_q      <= '0;
            hilo_busy_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            hilo_busy_q <= hilo_busy_d;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[wr_ptr_q] <= if_inst;
            mem_pc[wr_ptr_q]   <= if_pc;
        end
    end
endmodule
